text_console_writer: RTL and testbench

Character-stream front end that turns a byte stream of ASCII text and control codes into single-cell writes on the screen RAM write port (`address_w`, `data`, `we`) of the 1280x800 text-mode VGA path. It keeps a hardware cursor over the 160x50 cell grid and handles line wrap, newline, carriage return, backspace and full-screen clear. It sits between the CPU's memory-mapped console register and the VGA block, in the pixel-clock domain of the screen RAM write port.

---
 rtl/text_console_pkg.sv | 29 ++
 rtl/text_console_writer.sv | 135 +++++++++++++
 tb/tb_text_console_writer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console writer.
package text_console_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR_ROW,
      CLEAR_ALL
   } console_state_t;

   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_FF    = 8'h0C;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam int DEFAULT_COLS = 160;
   localparam int DEFAULT_ROWS = 50;
   localparam int SCREEN_CELLS = DEFAULT_COLS * DEFAULT_ROWS;

   // row*160 as two shifts; the grid is fixed at 160 columns, so no multiplier is needed
   function automatic logic [12:0] row_base(input logic [5:0] row);
      return (13'(row) << 7) + (13'(row) << 5);
   endfunction

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h7E);
   endfunction

endpackage

// File: rtl/text_console_writer.sv
// Byte-stream console: maps ASCII text and control codes onto single-cell
// screen RAM writes while tracking a wrapping cursor over the text grid.
module text_console_writer
   import text_console_pkg::*;
#(
   parameter int         COLS  = DEFAULT_COLS,
   parameter int         ROWS  = DEFAULT_ROWS,
   parameter logic [7:0] BLANK = ASCII_SPACE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [12:0] address_w,
   output logic [7:0]  data,
   output logic        we,
   output logic [7:0]  cursor_col,
   output logic [5:0]  cursor_row,
   output logic        busy
);

   localparam logic [7:0]  LAST_COL  = 8'(COLS - 1);
   localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
   localparam logic [12:0] ROW_END   = 13'(COLS - 1);
   localparam logic [12:0] SCREEN_END = 13'(COLS * ROWS - 1);

   console_state_t state, state_n;
   logic [12:0] sweep, sweep_n;
   logic [7:0]  col, col_n;
   logic [5:0]  row, row_n, row_adv;
   logic [12:0] addr_n;
   logic [7:0]  data_n;
   logic        we_n;

   assign in_ready   = (state == IDLE);
   assign busy       = (state != IDLE);
   assign cursor_col = col;
   assign cursor_row = row;
   assign row_adv    = (row == LAST_ROW) ? 6'd0 : row + 6'd1;

   // NOTE: all state lives in one clocked block updated with <=; the
   // combinational block below only computes next values, so every output
   // gets a default first and no latch can be inferred.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         sweep     <= '0;
         col       <= '0;
         row       <= '0;
         we        <= 1'b0;
         address_w <= '0;
         data      <= '0;
      end else begin
         state     <= state_n;
         sweep     <= sweep_n;
         col       <= col_n;
         row       <= row_n;
         we        <= we_n;
         address_w <= addr_n;
         data      <= data_n;
      end
   end

   always_comb begin
      state_n = state;
      sweep_n = sweep;
      col_n   = col;
      row_n   = row;
      we_n    = 1'b0;
      addr_n  = address_w;
      data_n  = data;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (is_printable(in_data)) begin
                  we_n   = 1'b1;
                  addr_n = row_base(row) + 13'(col);
                  data_n = in_data;
                  if (col == LAST_COL) begin
                     col_n   = '0;
                     row_n   = row_adv;
                     sweep_n = '0;
                     state_n = CLEAR_ROW;
                  end else begin
                     col_n = col + 8'd1;
                  end
               end else begin
                  case (in_data)
                     ASCII_LF: begin
                        col_n   = '0;
                        row_n   = row_adv;
                        sweep_n = '0;
                        state_n = CLEAR_ROW;
                     end
                     ASCII_CR: col_n = '0;
                     ASCII_BS: begin
                        if (col != 8'd0) begin
                           col_n  = col - 8'd1;
                           we_n   = 1'b1;
                           addr_n = row_base(row) + 13'(col - 8'd1);
                           data_n = BLANK;
                        end
                     end
                     ASCII_FF: begin
                        col_n   = '0;
                        row_n   = '0;
                        sweep_n = '0;
                        state_n = CLEAR_ALL;
                     end
                     default: ;
                  endcase
               end
            end
         end
         CLEAR_ROW: begin
            // cursor row already points at the row being blanked
            we_n   = 1'b1;
            addr_n = row_base(row) + sweep;
            data_n = BLANK;
            if (sweep == ROW_END) state_n = IDLE;
            else                  sweep_n = sweep + 13'd1;
         end
         CLEAR_ALL: begin
            we_n   = 1'b1;
            addr_n = sweep;
            data_n = BLANK;
            if (sweep == SCREEN_END) state_n = IDLE;
            else                     sweep_n = sweep + 13'd1;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: vector table plus multi-cycle
// sequences for wrap, clears and mid-sweep reset.
module tb_text_console_writer;
   import text_console_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [12:0] address_w;
   logic [7:0]  data;
   logic        we;
   logic [7:0]  cursor_col;
   logic [5:0]  cursor_row;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        v;
      logic [7:0]  b;
      logic        we;
      logic [12:0] addr;
      logic [7:0]  d;
      logic [7:0]  col;
      logic [5:0]  row;
   } vec_t;

   vec_t vecs[14];

   text_console_writer dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .address_w  (address_w),
      .data       (data),
      .we         (we),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic v, input logic [7:0] b);
      @(negedge clk);
      in_valid = v;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_check(input string name, input logic v, input logic [7:0] b,
                             input logic exp_we, input logic [12:0] exp_addr,
                             input logic [7:0] exp_data, input logic [7:0] exp_col,
                             input logic [5:0] exp_row);
      send(v, b);
      check({name, " we"}, 32'(we), 32'(exp_we));
      if (exp_we) begin
         check({name, " addr"}, 32'(address_w), 32'(exp_addr));
         check({name, " data"}, 32'(data), 32'(exp_data));
      end
      check({name, " col"}, 32'(cursor_col), 32'(exp_col));
      check({name, " row"}, 32'(cursor_row), 32'(exp_row));
      check({name, " in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic wait_ready(input int budget);
      int n = 0;
      while (!in_ready && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("wait_ready", 32'(in_ready), 32'd1);
   endtask

   // Expects one BLANK write per cycle across a full row starting at base.
   task automatic expect_row_clear(input string name, input int base);
      for (int i = 0; i < 160; i++) begin
         @(posedge clk);
         #1;
         check({name, " we"}, 32'(we), 32'd1);
         check({name, " addr"}, 32'(address_w), 32'(base + i));
         check({name, " data"}, 32'(data), 32'h20);
         check({name, " in_ready"}, 32'(in_ready), 32'(i == 159));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 8'h41, 1'b1, 13'd0, 8'h41, 8'd1, 6'd0};
      vecs[1]  = '{1'b1, 8'h42, 1'b1, 13'd1, 8'h42, 8'd2, 6'd0};
      vecs[2]  = '{1'b0, 8'h58, 1'b0, 13'd0, 8'h00, 8'd2, 6'd0};
      vecs[3]  = '{1'b1, 8'h0D, 1'b0, 13'd0, 8'h00, 8'd0, 6'd0};
      vecs[4]  = '{1'b1, 8'h43, 1'b1, 13'd0, 8'h43, 8'd1, 6'd0};
      vecs[5]  = '{1'b1, 8'h08, 1'b1, 13'd0, 8'h20, 8'd0, 6'd0};
      vecs[6]  = '{1'b1, 8'h08, 1'b0, 13'd0, 8'h00, 8'd0, 6'd0};
      vecs[7]  = '{1'b1, 8'h07, 1'b0, 13'd0, 8'h00, 8'd0, 6'd0};
      vecs[8]  = '{1'b1, 8'h80, 1'b0, 13'd0, 8'h00, 8'd0, 6'd0};
      vecs[9]  = '{1'b1, 8'h7F, 1'b0, 13'd0, 8'h00, 8'd0, 6'd0};
      vecs[10] = '{1'b1, 8'h7E, 1'b1, 13'd0, 8'h7E, 8'd1, 6'd0};
      vecs[11] = '{1'b1, 8'h20, 1'b1, 13'd1, 8'h20, 8'd2, 6'd0};
      vecs[12] = '{1'b1, 8'h1F, 1'b0, 13'd0, 8'h00, 8'd2, 6'd0};
      vecs[13] = '{1'b1, 8'hFF, 1'b0, 13'd0, 8'h00, 8'd2, 6'd0};

      // reset values while reset is held
      #12;
      check("rst we", 32'(we), 32'd0);
      check("rst addr", 32'(address_w), 32'd0);
      check("rst data", 32'(data), 32'd0);
      check("rst col", 32'(cursor_col), 32'd0);
      check("rst row", 32'(cursor_row), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 14; i++)
         send_check($sformatf("vec%0d", i), vecs[i].v, vecs[i].b, vecs[i].we,
                    vecs[i].addr, vecs[i].d, vecs[i].col, vecs[i].row);

      // wrap at (159,3): 'Z' at 639, then row 4 blanked at 640..799
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send(1'b1, ASCII_LF);
         wait_ready(200);
      end
      for (int i = 0; i < 159; i++) send(1'b1, 8'h78);
      check("pre-wrap col", 32'(cursor_col), 32'd159);
      check("pre-wrap row", 32'(cursor_row), 32'd3);
      send(1'b1, 8'h5A);
      check("wrap we", 32'(we), 32'd1);
      check("wrap addr", 32'(address_w), 32'd639);
      check("wrap data", 32'(data), 32'h5A);
      check("wrap col", 32'(cursor_col), 32'd0);
      check("wrap row", 32'(cursor_row), 32'd4);
      check("wrap in_ready", 32'(in_ready), 32'd0);
      check("wrap busy", 32'(busy), 32'd1);
      expect_row_clear("wrap clr", 640);
      @(posedge clk);
      #1;
      check("wrap after we", 32'(we), 32'd0);

      // LF on row 49 wraps to row 0 and blanks it
      for (int i = 0; i < 45; i++) begin
         send(1'b1, ASCII_LF);
         wait_ready(200);
      end
      check("row49", 32'(cursor_row), 32'd49);
      send(1'b1, ASCII_LF);
      check("lf49 we", 32'(we), 32'd0);
      check("lf49 col", 32'(cursor_col), 32'd0);
      check("lf49 row", 32'(cursor_row), 32'd0);
      check("lf49 in_ready", 32'(in_ready), 32'd0);
      expect_row_clear("lf49 clr", 0);

      // backspace sequence and CR
      send_check("bs A", 1'b1, 8'h41, 1'b1, 13'd0, 8'h41, 8'd1, 6'd0);
      send_check("bs B", 1'b1, 8'h42, 1'b1, 13'd1, 8'h42, 8'd2, 6'd0);
      send_check("bs 1", 1'b1, ASCII_BS, 1'b1, 13'd1, 8'h20, 8'd1, 6'd0);
      send_check("bs 2", 1'b1, ASCII_BS, 1'b1, 13'd0, 8'h20, 8'd0, 6'd0);
      send_check("bs 3", 1'b1, ASCII_BS, 1'b0, 13'd0, 8'h00, 8'd0, 6'd0);
      for (int i = 0; i < 5; i++) send(1'b1, 8'h61 + 8'(i));
      check("cr pre col", 32'(cursor_col), 32'd5);
      send_check("cr", 1'b1, ASCII_CR, 1'b0, 13'd0, 8'h00, 8'd0, 6'd0);

      // full clear with 'Q' pending throughout
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = ASCII_FF;
      @(posedge clk);
      #1;
      check("ff we", 32'(we), 32'd0);
      check("ff busy", 32'(busy), 32'd1);
      check("ff in_ready", 32'(in_ready), 32'd0);
      check("ff col", 32'(cursor_col), 32'd0);
      check("ff row", 32'(cursor_row), 32'd0);
      in_data = 8'h51;
      for (int i = 0; i < 8000; i++) begin
         @(posedge clk);
         #1;
         check("ff clr we", 32'(we), 32'd1);
         check("ff clr addr", 32'(address_w), 32'(i));
         check("ff clr data", 32'(data), 32'h20);
         check("ff clr busy", 32'(busy), 32'(i != 7999));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("q we", 32'(we), 32'd1);
      check("q addr", 32'(address_w), 32'd0);
      check("q data", 32'(data), 32'h51);
      check("q col", 32'(cursor_col), 32'd1);
      check("q row", 32'(cursor_row), 32'd0);

      // asynchronous reset in the middle of a full clear
      send(1'b1, ASCII_FF);
      for (int n = 0; n < 300; n++) begin
         @(posedge clk);
         #1;
         if (we && address_w == 13'd100) break;
      end
      check("mid addr", 32'(address_w), 32'd100);
      #2;
      reset = 1'b0;
      #1;
      check("mid rst we", 32'(we), 32'd0);
      check("mid rst addr", 32'(address_w), 32'd0);
      check("mid rst data", 32'(data), 32'd0);
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst in_ready", 32'(in_ready), 32'd1);
      check("mid rst col", 32'(cursor_col), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel in_ready", 32'(in_ready), 32'd1);
      check("rel busy", 32'(busy), 32'd0);
      send_check("bel", 1'b1, 8'h07, 1'b0, 13'd0, 8'h00, 8'd0, 6'd0);
      send_check("hi", 1'b1, 8'h80, 1'b0, 13'd0, 8'h00, 8'd0, 6'd0);
      begin
         int stray = 0;
         for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (we) stray++;
         end
         check("no resume", 32'(stray), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
